corelet_ctrl: RTL
=================

// Module: corelet_ctrl
// PURPOSE
//  Sequencer for the corelet datapath (L0, PE array, OFIFO, SFP accumulate) for one weight-stationary pass.
//  On start it runs five phases: stream col weight words into L0; replay them into the array as kernel-load;
//  wait for the kernel to settle; stream n_vec activation words through L0 into the array as execute;
//  drain n_vec OFIFO rows into the SFP with accumulate. Sits between the testbench/host stream and corelet.
// PARAMETERS
//  bw      4    activation/weight bit width
//  row     8    PE array rows (L0 word = bw*row bits)
//  col     8    PE array columns = number of weight words per pass
//  L0_LAT  1    cycles from l0_rd to valid L0 data at array input (inst_w delayed by this)
//  SETTLE  16   idle cycles between last kernel-load inst_w and first execute inst_w
//  CNT_W   8    width of vector/phase counters
// PORTS
//  clk          in   1          clock, all logic rising edge
//  reset        in   1          synchronous, active-high
//  start        in   1          1-cycle pulse, begins pass; ignored while busy
//  n_vec        in   CNT_W      activation vectors this pass, sampled on accepted start
//  busy         out  1          high from cycle after accepted start until done
//  done         out  1          1-cycle pulse at end of pass
//  in_valid     in   1          host stream word valid
//  in_ready     out  1          controller accepts word (fill phases only)
//  in_data      in   bw*row     host stream word (weights, then activations)
//  l0_wr        out  1          L0 write strobe
//  l0_wdata     out  bw*row     L0 write data (= in_data)
//  l0_rd        out  1          L0 read strobe
//  l0_ready     in   1          L0 can accept a write
//  inst_w       out  3          array instruction: 001 kernel load, 010 execute, 000 idle
//  ofifo_rd     out  1          OFIFO read strobe
//  ofifo_valid  in   1          OFIFO holds a complete row
//  sfp_acc      out  1          SFP accumulate enable
// BEHAVIOUR
//  Reset: state IDLE, all counters 0, busy/done/in_ready/l0_wr/l0_rd/ofifo_rd/sfp_acc = 0, inst_w = 000.
//  States: IDLE -> WFILL -> WLOAD -> SETTLE -> XFILL -> EXEC -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches n_vec, clears counters, -> WFILL next cycle.
//  WFILL/XFILL: in_ready = l0_ready; l0_wr = in_valid & l0_ready; counter++ per write.
//   WFILL -> WLOAD after col-th write; XFILL -> EXEC after n_vec-th write. No write when l0_ready=0.
//  WLOAD: l0_rd=1 for exactly col consecutive cycles. EXEC: l0_rd=1 for exactly n_vec cycles.
//  inst_w = 001 (WLOAD) or 010 (EXEC), driven through an L0_LAT-deep pipeline off l0_rd;
//   inst_w is nonzero on exactly the cycles where L0 data is at the array input.
//  SETTLE: counts SETTLE cycles starting after the last kernel-load inst_w cycle, inst_w=000.
//  EXEC -> DRAIN after last l0_rd; the inst_w pipeline continues to flush after the state change.
//  DRAIN: ofifo_rd = ofifo_valid while drained < n_vec; sfp_acc = ofifo_rd delayed 1 cycle
//   (aligned with OFIFO data). -> DONE after n_vec-th read and its trailing sfp_acc cycle.
//  DONE: done=1 one cycle, busy drops same cycle, -> IDLE.
//  n_vec=0: skip XFILL/EXEC/DRAIN; SETTLE -> DONE.
//  Back-to-back: start in DONE cycle is ignored; accepted start requires IDLE.
//  Counters saturate-free: CNT_W wide, compare by equality; n_vec up to 2^CNT_W-1.
//  Reset mid-pass: next cycle IDLE, inst_w pipeline flushed to 000, no done pulse.
//  Never: l0_wr outside fill states, l0_rd outside WLOAD/EXEC, ofifo_rd with ofifo_valid=0.
// TESTING
//  1 Basic: n_vec=4, in_valid always 1, l0_ready/ofifo_valid 1 -> 8 l0_wr, 8 l0_rd + 8 inst_w=001,
//    16 idle, 4 writes, 4 inst_w=010, 4 ofifo_rd + 4 sfp_acc (each 1 cycle later), one done pulse.
//  2 Backpressure: l0_ready toggles 1/0 in WFILL -> in_ready tracks it, exactly 8 writes, no write when 0.
//  3 Sparse OFIFO: ofifo_valid high 1 of 3 cycles, n_vec=3 -> ofifo_rd only when valid, 3 reads, then done.
//  4 n_vec=0 -> no XFILL/EXEC/DRAIN activity; done 1 cycle after SETTLE ends.
//  5 Reset asserted in EXEC -> next cycle all outputs at reset values; new start runs full pass cleanly.
//  6 start pulsed while busy and in DONE cycle -> ignored; n_vec change mid-pass has no effect.

Source files
------------

// File: rtl/corelet_ctrl.sv
// Pass sequencer for the corelet: weight fill, kernel load, settle, activation fill,
// execute and OFIFO drain into the SFP accumulator.
module corelet_ctrl #(
  parameter int unsigned bw     = 4,
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned L0_LAT = 1,
  parameter int unsigned SETTLE = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_vec,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [bw*row-1:0] in_data,
  output logic              l0_wr,
  output logic [bw*row-1:0] l0_wdata,
  output logic              l0_rd,
  input  logic              l0_ready,
  output logic [2:0]        inst_w,
  output logic              ofifo_rd,
  input  logic              ofifo_valid,
  output logic              sfp_acc
);

  typedef enum logic [2:0] {
    StIdle, StWfill, StWload, StSettle, StXfill, StExec, StDrain, StDone
  } state_e;

  localparam logic [CNT_W-1:0] ColLast    = CNT_W'(col - 1);
  // SETTLE idle cycles are counted only once the inst_w pipeline has flushed.
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(L0_LAT + SETTLE - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q, drained_q, n_vec_q;
  logic                    busy_q, done_q, sfp_acc_q;
  logic [L0_LAT-1:0][2:0]  pipe_q;
  logic                    fill;
  logic [2:0]              inst_code;

  assign fill     = (state_q == StWfill) || (state_q == StXfill);
  assign in_ready = fill & l0_ready;
  assign l0_wr    = fill & in_valid & l0_ready;
  assign l0_wdata = in_data;
  assign l0_rd    = (state_q == StWload) || (state_q == StExec);
  assign ofifo_rd = (state_q == StDrain) && (drained_q != n_vec_q) && ofifo_valid;
  assign inst_w   = pipe_q[L0_LAT-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign sfp_acc  = sfp_acc_q;

  always_comb begin
    inst_code = 3'b000;
    if (state_q == StWload) inst_code = 3'b001;
    else if (state_q == StExec) inst_code = 3'b010;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      drained_q <= '0;
      n_vec_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sfp_acc_q <= 1'b0;
      pipe_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      sfp_acc_q <= ofifo_rd;
      pipe_q[0] <= inst_code;
      for (int i = 1; i < int'(L0_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_vec_q   <= n_vec;
            cnt_q     <= '0;
            drained_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StWfill;
          end
        end
        StWfill: begin
          if (l0_wr) begin
            if (cnt_q == ColLast) begin
              cnt_q   <= '0;
              state_q <= StWload;
            end else cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWload: begin
          if (cnt_q == ColLast) begin
            cnt_q   <= '0;
            state_q <= StSettle;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q <= '0;
            if (n_vec_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else state_q <= StXfill;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        StXfill: begin
          if (l0_wr) begin
            if (cnt_q == n_vec_q - CNT_W'(1)) begin
              cnt_q   <= '0;
              state_q <= StExec;
            end else cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StExec: begin
          if (cnt_q == n_vec_q - CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= StDrain;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        StDrain: begin
          if (ofifo_rd) drained_q <= drained_q + CNT_W'(1);
          // Leave one cycle after the last read so its sfp_acc lands inside the pass.
          if (drained_q == n_vec_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
